// File: rtl/nonce_tx_pkg.sv
// Shared definitions for the nonce uplink: transmitter states, framing
// constants and a constant-width helper shared with the nonce hub.
package nonce_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // One start bit, eight data bits, one stop bit.
    localparam int FRAME_BITS  = 10;
    localparam int NONCE_BYTES = 4;

    // Smallest width able to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/nonce_serial_tx_if.sv
// Handshake and line signals between the nonce hub and the serial uplink.
interface nonce_serial_tx_if;
    logic [31:0] word_in;
    logic        send;
    logic        busy;
    logic        txd;

    modport master (
        output word_in,
        output send,
        input  busy,
        input  txd
    );

    modport slave (
        input  word_in,
        input  send,
        output busy,
        output txd
    );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Baud-rate divider: counts uart_clk cycles within one bit period and
// pulses bit_tick on the final cycle so the FSM advances exactly once per bit.
module uart_tx_bit_timer
    import nonce_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;
    logic             wrap;

    assign wrap     = (baud_cnt == LAST_CNT);
    assign bit_tick = enable && !clear && wrap;

    // Free-run 0..CLKS_PER_BIT-1 while a frame is on the line; restart on accept.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            baud_cnt <= '0;
        end else if (enable) begin
            baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nonce_serial_tx.sv
// Serial uplink: takes one 32-bit nonce per send strobe and shifts it out as
// four 8N1 frames, most-significant byte first, holding busy throughout.
module nonce_serial_tx
    import nonce_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = NONCE_BYTES
) (
    input logic              uart_clk,
    input logic              rst,
    nonce_serial_tx_if.slave bus
);

    localparam logic [2:0] LAST_BIT  = 3'(FRAME_BITS - 3);
    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    tx_state_t   state;
    tx_state_t   next_state;
    logic [31:0] shift_reg;
    logic [31:0] shift_next;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_next;
    logic        txd_q;
    logic        txd_d;
    logic        accept;
    logic        bit_tick;
    logic        last_byte;

    assign accept    = (state == IDLE) && bus.send;
    assign last_byte = (byte_idx == LAST_BYTE);

    // Including send lets the hub see busy in the very cycle it strobes.
    assign bus.busy = bus.send || (state != IDLE);
    assign bus.txd  = txd_q;

    uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (uart_clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (state != IDLE),
        .bit_tick(bit_tick)
    );

    // State and datapath registers; reset abandons any word in flight.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state     <= next_state;
            shift_reg <= shift_next;
            byte_idx  <= byte_next;
            bit_idx   <= bit_next;
            txd_q     <= txd_d;
        end
    end

    // Frame sequencing: start, eight data bits, stop, repeated per byte.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (bus.send) next_state = START;
            START: if (bit_tick) next_state = DATA;
            DATA:  if (bit_tick && (bit_idx == LAST_BIT)) next_state = STOP;
            STOP:  if (bit_tick) next_state = last_byte ? IDLE : START;
            default: next_state = IDLE;
        endcase
    end

    // Word latch, bit/byte indices; the next byte is brought to the top on each stop.
    always_comb begin
        shift_next = shift_reg;
        byte_next  = byte_idx;
        bit_next   = bit_idx;
        if (accept) begin
            shift_next = bus.word_in;
            byte_next  = '0;
            bit_next   = '0;
        end else if (bit_tick) begin
            case (state)
                START: bit_next = '0;
                DATA: begin
                    if (bit_idx != LAST_BIT) begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (!last_byte) begin
                        byte_next  = byte_idx + 1'b1;
                        shift_next = {shift_reg[23:0], 8'h00};
                    end
                end
                default: ;
            endcase
        end
    end

    // Line level for the coming cycle, registered so txd is glitch-free.
    always_comb begin
        txd_d = 1'b1;
        case (next_state)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_next[{2'b11, bit_next}];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_nonce_serial_tx.sv
// Self-checking bench for nonce_serial_tx: a waveform-level reference model
// predicts txd/busy every cycle, and a line decoder pins literal byte values.
module tb_nonce_serial_tx;
    import nonce_tx_pkg::*;

    localparam int C = 4;

    logic uart_clk;
    logic rst;

    nonce_serial_tx_if bus ();

    nonce_serial_tx #(
        .CLKS_PER_BIT(C),
        .NUM_BYTES   (NONCE_BYTES)
    ) dut (
        .uart_clk(uart_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    bit   chk_en      = 0;
    bit   log_en      = 0;
    bit   busy_cnt_en = 0;
    int   busy_cnt    = 0;
    logic model_q[$];
    logic line_log[$];
    logic [7:0] dec_bytes[$];
    int   dec_starts[$];
    int   dec_err;

    // Free-running 10-unit clock.
    initial begin
        uart_clk = 1'b0;
        forever #5 uart_clk = ~uart_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected line waveform of a whole word, one entry per uart_clk cycle.
    task automatic buildFrame(input logic [31:0] word);
        logic [7:0] val;
        for (int b = 0; b < NONCE_BYTES; b++) begin
            val = 8'(word >> (24 - 8 * b));
            repeat (C) model_q.push_back(1'b0);
            for (int j = 0; j < 8; j++) begin
                repeat (C) model_q.push_back(val[j]);
            end
            repeat (C) model_q.push_back(1'b1);
        end
    endtask

    // Reference model: an empty queue means idle; otherwise the head is the line level.
    always @(posedge uart_clk) begin
        if (rst) begin
            model_q.delete();
        end else if (model_q.size() == 0) begin
            if (bus.send) buildFrame(bus.word_in);
        end else begin
            void'(model_q.pop_front());
        end
    end

    // Per-cycle compare mid-cycle, plus line capture and busy-cycle counting.
    always @(negedge uart_clk) begin
        if (chk_en) begin
            checkOutput("txd", 32'(bus.txd), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd1);
            checkOutput("busy", 32'(bus.busy), 32'(bus.send || (model_q.size() != 0)));
            if (log_en) line_log.push_back(bus.txd);
            if (busy_cnt_en && bus.busy) busy_cnt = busy_cnt + 1;
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    // One-cycle send strobe; busy must already be high in the strobe cycle.
    task automatic applyStimulus(input logic [31:0] word);
        bus.word_in = word;
        bus.send    = 1'b1;
        @(negedge uart_clk);
        checkOutput("busy_comb", 32'(bus.busy), 32'd1);
        @(posedge uart_clk);
        #1;
        bus.send = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (bus.busy && n < limit) begin
            @(posedge uart_clk);
            #1;
            n = n + 1;
        end
        if (bus.busy) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL wait_idle: busy still 1 after %0d cycles, expected 0", limit);
        end
    endtask

    // Independent UART receiver over the captured line, sampling mid-bit.
    task automatic decodeLog();
        int i;
        int mid;
        logic [7:0] val;
        dec_bytes.delete();
        dec_starts.delete();
        dec_err = 0;
        i = 0;
        while (i < line_log.size()) begin
            if (line_log[i] == 1'b0) begin
                mid = i + C / 2;
                if (mid + 9 * C >= line_log.size()) begin
                    dec_err = dec_err + 1;
                    break;
                end
                if (line_log[mid] != 1'b0) dec_err = dec_err + 1;
                for (int j = 0; j < 8; j++) val[j] = line_log[mid + (j + 1) * C];
                if (line_log[mid + 9 * C] != 1'b1) dec_err = dec_err + 1;
                dec_bytes.push_back(val);
                dec_starts.push_back(i);
                i = mid + 9 * C;
            end
            i = i + 1;
        end
    endtask

    task automatic checkWordBytes(input string name, input int first, input logic [31:0] word);
        for (int b = 0; b < NONCE_BYTES; b++) begin
            if (first + b < dec_bytes.size()) begin
                checkOutput(name, 32'(dec_bytes[first + b]), 32'(8'(word >> (24 - 8 * b))));
            end else begin
                checkOutput(name, 32'hFFFF_FFFF, 32'(8'(word >> (24 - 8 * b))));
            end
        end
    endtask

    task automatic startCapture();
        line_log.delete();
        log_en = 1'b1;
    endtask

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by randomized words with spurious strobes.
    initial begin
        int zeros;
        logic [31:0] w;

        rst         = 1'b1;
        bus.send    = 1'b0;
        bus.word_in = '0;

        @(posedge uart_clk);
        #1;
        chk_en = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        @(negedge uart_clk);
        checkOutput("reset_txd", 32'(bus.txd), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        startCapture();
        idleCycles(100);
        zeros = 0;
        foreach (line_log[i]) if (line_log[i] == 1'b0) zeros = zeros + 1;
        checkOutput("reset_quiet", 32'(zeros), 32'd0);

        $display("[TB] single word");
        startCapture();
        busy_cnt    = 0;
        busy_cnt_en = 1'b1;
        @(negedge uart_clk);
        checkOutput("pre_send_txd", 32'(bus.txd), 32'd1);
        @(posedge uart_clk);
        #1;
        applyStimulus(32'h1234_5678);
        @(negedge uart_clk);
        checkOutput("txd_fall", 32'(bus.txd), 32'd0);
        @(posedge uart_clk);
        #1;
        waitIdle(500);
        busy_cnt_en = 1'b0;
        checkOutput("busy_cycles", 32'(busy_cnt), 32'd161);
        idleCycles(5);
        decodeLog();
        checkOutput("single_nbytes", 32'(dec_bytes.size()), 32'd4);
        checkOutput("single_framing", 32'(dec_err), 32'd0);
        checkWordBytes("single_byte", 0, 32'h1234_5678);

        $display("[TB] ignored request");
        startCapture();
        applyStimulus(32'h1234_5678);
        idleCycles(48);
        applyStimulus(32'hDEAD_BEEF);
        waitIdle(500);
        idleCycles(100);
        decodeLog();
        checkOutput("ignored_nbytes", 32'(dec_bytes.size()), 32'd4);
        checkOutput("ignored_framing", 32'(dec_err), 32'd0);
        checkWordBytes("ignored_byte", 0, 32'h1234_5678);

        $display("[TB] back-to-back");
        startCapture();
        applyStimulus(32'hAABB_CCDD);
        waitIdle(500);
        applyStimulus(32'h00FF_00FF);
        waitIdle(500);
        idleCycles(5);
        decodeLog();
        checkOutput("b2b_nbytes", 32'(dec_bytes.size()), 32'd8);
        checkOutput("b2b_framing", 32'(dec_err), 32'd0);
        checkWordBytes("b2b_first", 0, 32'hAABB_CCDD);
        checkWordBytes("b2b_second", 4, 32'h00FF_00FF);
        if (dec_starts.size() >= 5) begin
            checkOutput("b2b_gap", 32'(dec_starts[4] - dec_starts[3]), 32'(10 * C + 1));
        end else begin
            checkOutput("b2b_gap", 32'hFFFF_FFFF, 32'(10 * C + 1));
        end

        $display("[TB] reset mid-word");
        applyStimulus(32'h55AA_1234);
        idleCycles(10 * C + C + 8);
        rst = 1'b1;
        @(posedge uart_clk);
        #1;
        @(negedge uart_clk);
        checkOutput("rst_mid_txd", 32'(bus.txd), 32'd1);
        @(posedge uart_clk);
        #1;
        rst = 1'b0;
        @(negedge uart_clk);
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        @(posedge uart_clk);
        #1;
        startCapture();
        applyStimulus(32'h0102_0304);
        waitIdle(500);
        idleCycles(5);
        decodeLog();
        checkOutput("after_rst_nbytes", 32'(dec_bytes.size()), 32'd4);
        checkOutput("after_rst_framing", 32'(dec_err), 32'd0);
        checkWordBytes("after_rst_byte", 0, 32'h0102_0304);

        $display("[TB] randomized words");
        for (int it = 0; it < 6; it++) begin
            w = $urandom;
            idleCycles($urandom_range(0, 15));
            startCapture();
            applyStimulus(w);
            idleCycles($urandom_range(5, 150));
            applyStimulus($urandom);
            waitIdle(500);
            idleCycles(3);
            decodeLog();
            checkOutput("rand_nbytes", 32'(dec_bytes.size()), 32'd4);
            checkOutput("rand_framing", 32'(dec_err), 32'd0);
            checkWordBytes("rand_byte", 0, w);
        end

        log_en = 1'b0;
        idleCycles(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
